// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths and the butterfly product-select codes
// used by both the butterfly controller and the datapath.
package fft_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TW_W_DEF   = 16;

    typedef enum logic [1:0] {
        SEL_BRWR = 2'd0,
        SEL_BIWI = 2'd1,
        SEL_BRWI = 2'd2,
        SEL_BIWR = 2'd3
    } sel_e;

endpackage

// File: rtl/fft_butterfly_dp_mult.sv
// Shared signed DATA_W x TW_W multiplier with its 4:1 operand mux. Kept separate
// so a DSP-mapped or pipelined multiplier can be dropped in later.
module bf_mult
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF
) (
    input  logic        [1:0]             s,
    input  logic signed [DATA_W-1:0]      br,
    input  logic signed [DATA_W-1:0]      bi,
    input  logic signed [TW_W-1:0]        wr,
    input  logic signed [TW_W-1:0]        wi,
    output logic signed [DATA_W+TW_W-1:0] p
);

    localparam int PW = DATA_W + TW_W;

    logic signed [DATA_W-1:0] op_x;
    logic signed [TW_W-1:0]   op_y;

    always_comb begin
        op_x = br;
        op_y = wr;
        case (sel_e'(s))
            SEL_BRWR: begin op_x = br; op_y = wr; end
            SEL_BIWI: begin op_x = bi; op_y = wi; end
            SEL_BRWI: begin op_x = br; op_y = wi; end
            SEL_BIWR: begin op_x = bi; op_y = wr; end
            default:  begin op_x = br; op_y = wr; end
        endcase
    end

    assign p = PW'(op_x) * PW'(op_y);

endmodule

// File: rtl/fft_butterfly_dp.sv
// Radix-2 DIT butterfly datapath: t = B*W accumulated over four controller
// cycles through one shared multiplier, then Y0 = A + t and Y1 = A - t.
module fft_butterfly_dp
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic        [1:0]        s,
    input  logic                     load,
    input  logic                     en_real,
    input  logic                     en_imag,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    output logic signed [DATA_W:0]   y0_re,
    output logic signed [DATA_W:0]   y0_im,
    output logic signed [DATA_W:0]   y1_re,
    output logic signed [DATA_W:0]   y1_im,
    output logic                     out_valid
);

    localparam int PW = DATA_W + TW_W;
    localparam int AW = PW + 1;
    localparam int OW = DATA_W + 1;

    logic signed [DATA_W-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
    logic signed [TW_W-1:0]   w_re_p0, w_im_p0;
    logic signed [AW-1:0]     acc_re_p1, acc_im_p1;
    logic signed [PW-1:0]     p;
    logic signed [AW-1:0]     p_ext, p_s3, t_im_sum;
    logic signed [OW-1:0]     t_re, t_im, a_re_x, a_im_x;

    // Drop the Q1.(TW_W-1) fraction bits by arithmetic shift (truncation, no
    // rounding) and keep DATA_W+1 bits; |W| <= 1 guarantees no wrap here.
    function automatic logic signed [OW-1:0] scale_trunc(input logic signed [AW-1:0] x);
        return OW'(x >>> (TW_W - 1));
    endfunction

    function automatic logic signed [OW-1:0] sext_data(input logic signed [DATA_W-1:0] x);
        return OW'(x);
    endfunction

    // ---- stage p0: operand registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_re_p0 <= '0;
            a_im_p0 <= '0;
            b_re_p0 <= '0;
            b_im_p0 <= '0;
            w_re_p0 <= '0;
            w_im_p0 <= '0;
        end else if (load) begin
            a_re_p0 <= a_re;
            a_im_p0 <= a_im;
            b_re_p0 <= b_re;
            b_im_p0 <= b_im;
            w_re_p0 <= w_re;
            w_im_p0 <= w_im;
        end
    end

    bf_mult #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W)
    ) u_mult (
        .s  (s),
        .br (b_re_p0),
        .bi (b_im_p0),
        .wr (w_re_p0),
        .wi (w_im_p0),
        .p  (p)
    );

    assign p_ext = AW'(p);

    // ---- stage p1: product accumulation, selected by s ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_re_p1 <= '0;
            acc_im_p1 <= '0;
        end else if (load) begin
            acc_re_p1 <= '0;
            acc_im_p1 <= '0;
        end else begin
            case (sel_e'(s))
                SEL_BRWR: acc_re_p1 <= p_ext;
                SEL_BIWI: acc_re_p1 <= acc_re_p1 - p_ext;
                SEL_BRWI: acc_im_p1 <= p_ext;
                default:  ;
            endcase
        end
    end

    // The last product (bi*wr) bypasses acc_im so the frame fits in 5 cycles.
    assign p_s3     = (sel_e'(s) == SEL_BIWR) ? p_ext : '0;
    assign t_im_sum = acc_im_p1 + p_s3;
    assign t_re     = scale_trunc(acc_re_p1);
    assign t_im     = scale_trunc(t_im_sum);
    assign a_re_x   = sext_data(a_re_p0);
    assign a_im_x   = sext_data(a_im_p0);

    // ---- stage p2: butterfly outputs ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y0_re <= '0;
            y1_re <= '0;
            y0_im <= '0;
            y1_im <= '0;
        end else begin
            if (en_real) begin
                y0_re <= a_re_x + t_re;
                y1_re <= a_re_x - t_re;
            end
            if (en_imag) begin
                y0_im <= a_im_x + t_im;
                y1_im <= a_im_x - t_im;
            end
        end
    end

    // A load coinciding with en is the controller start state, not a result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= en_real & en_imag & ~load;
        end
    end

endmodule

// File: tb/tb_fft_butterfly_dp.sv
// Bench for fft_butterfly_dp: directed test-plan vectors plus random frames,
// compared every cycle against a complex-arithmetic model of the butterfly.
module tb_fft_butterfly_dp;

    localparam int DATA_W = 16;
    localparam int TW_W   = 16;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic        [1:0]        s = 2'd3;
    logic                     load = 1'b0;
    logic                     en_real = 1'b0;
    logic                     en_imag = 1'b0;
    logic signed [DATA_W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic signed [TW_W-1:0]   w_re = '0, w_im = '0;
    logic signed [DATA_W:0]   y0_re, y0_im, y1_re, y1_im;
    logic                     out_valid;

    fft_butterfly_dp #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s),
        .load      (load),
        .en_real   (en_real),
        .en_imag   (en_imag),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .y0_re     (y0_re),
        .y0_im     (y0_im),
        .y1_re     (y1_re),
        .y1_im     (y1_im),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    logic [16:0] exp_y0_re = '0, exp_y0_im = '0, exp_y1_re = '0, exp_y1_im = '0;
    logic        exp_valid = 1'b0;
    int          checks = 0;
    int          passes = 0;
    int          vld_seen = 0;
    int          vld_expected = 0;
    bit          cmp_on = 1'b0;

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%05h, expected 0x%05h (t=%0t)", name, act, req, $time);
    endtask

    // One output component: a +/- (prod >>> 15), t truncated to 17 bits, result wraps to 17 bits.
    function automatic logic [16:0] bf(input logic signed [15:0] a, input longint prod, input bit minus);
        longint             t;
        logic signed [16:0] t17;
        t   = prod >>> 15;
        t17 = t[16:0];
        if (minus) return 17'(longint'(a) - longint'(t17));
        else       return 17'(longint'(a) + longint'(t17));
    endfunction

    task automatic set_expect(input logic signed [15:0] ar, ai, br, bi, wr, wi);
        longint pr, pi;
        pr = longint'(br) * longint'(wr) - longint'(bi) * longint'(wi);
        pi = longint'(br) * longint'(wi) + longint'(bi) * longint'(wr);
        exp_y0_re = bf(ar, pr, 1'b0);
        exp_y1_re = bf(ar, pr, 1'b1);
        exp_y0_im = bf(ai, pi, 1'b0);
        exp_y1_im = bf(ai, pi, 1'b1);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("y0_re", y0_re, exp_y0_re);
            chk("y1_re", y1_re, exp_y1_re);
            chk("y0_im", y0_im, exp_y0_im);
            chk("y1_im", y1_im, exp_y1_im);
            chk("out_valid", {16'd0, out_valid}, {16'd0, exp_valid});
            if (out_valid === 1'b1) vld_seen++;
        end
    end

    task automatic step(input logic ld, input logic [1:0] sel, input logic en);
        load    = ld;
        s       = sel;
        en_real = en;
        en_imag = en;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        load      = 1'b0;
        en_real   = 1'b0;
        en_imag   = 1'b0;
    endtask

    task automatic scramble_ports();
        a_re = 16'($urandom); a_im = 16'($urandom);
        b_re = 16'($urandom); b_im = 16'($urandom);
        w_re = 16'($urandom); w_im = 16'($urandom);
    endtask

    // Full controller frame; start_en models the controller start state (load with en).
    task automatic frame(input logic signed [15:0] ar, ai, br, bi, wr, wi, input bit start_en);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        step(1'b1, 2'd3, start_en);
        scramble_ports();
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd1, 1'b0);
        step(1'b0, 2'd2, 1'b0);
        step(1'b0, 2'd3, 1'b1);
        set_expect(ar, ai, br, bi, wr, wi);
        exp_valid = 1'b1;
        vld_expected++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'($urandom_range(3)), 1'b0);
    endtask

    task automatic chk_out(input string tag, input logic [16:0] r0, r1, i0, i1);
        chk({tag, "_y0_re"}, y0_re, r0);
        chk({tag, "_y1_re"}, y1_re, r1);
        chk({tag, "_y0_im"}, y0_im, i0);
        chk({tag, "_y1_im"}, y1_im, i1);
    endtask

    initial begin
        #2;
        chk_out("reset", 17'h0, 17'h0, 17'h0, 17'h0);
        chk("reset_valid", {16'd0, out_valid}, 17'h0);
        #10;
        reset  = 1'b0;
        cmp_on = 1'b1;

        // start state overlap, then the real-scaling vector
        frame(16'sh1000, 16'sh0000, 16'sh2000, 16'sh0000, 16'sh4000, 16'sh0000, 1'b1);
        chk_out("real_scale", 17'h02000, 17'h00000, 17'h0, 17'h0);
        chk("real_scale_valid", {16'd0, out_valid}, 17'h1);
        idle(1);
        chk("real_scale_valid_drop", {16'd0, out_valid}, 17'h0);

        frame(16'sh0000, 16'sh0000, 16'sh2000, 16'sh0000, 16'sh0000, 16'sh4000, 1'b0);
        chk_out("imag_tw", 17'h00000, 17'h00000, 17'h01000, 17'h1F000);
        idle(2);

        frame(16'sh0000, 16'sh0000, 16'sh2000, -16'sh2000, 16'sh4000, 16'sh4000, 1'b0);
        chk_out("complex", 17'h02000, 17'h1E000, 17'h00000, 17'h00000);

        frame(16'sh7FFF, 16'sh0000, 16'sh7FFF, 16'sh0000, 16'sh7FFF, 16'sh0000, 1'b0);
        chk_out("growth", 17'h0FFFD, 17'h00001, 17'h0, 17'h0);
        idle(1);

        // load during s=2 aborts the partial frame
        scramble_ports();
        step(1'b1, 2'd3, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd1, 1'b0);
        frame(16'sh0123, -16'sh0456, 16'sh1111, 16'sh2222, -16'sh3000, 16'sh1800, 1'b0);
        idle(2);

        // asynchronous reset during s=1
        scramble_ports();
        step(1'b1, 2'd3, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        s = 2'd1;
        #2;
        reset = 1'b1;
        #1;
        exp_y0_re = '0; exp_y1_re = '0; exp_y0_im = '0; exp_y1_im = '0; exp_valid = 1'b0;
        chk_out("async_reset", 17'h0, 17'h0, 17'h0, 17'h0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        frame(16'sh0800, 16'sh0400, -16'sh1000, 16'sh0C00, 16'sh2D41, -16'sh2D41, 1'b0);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 1'b0);
            idle($urandom_range(3));
        end

        @(negedge clk);
        #1;
        cmp_on = 1'b0;
        chk("valid_pulse_count", 17'(vld_seen), 17'(vld_expected));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
